redundant_pair_generator: RTL
=============================

Name: redundant_pair_generator

Overview:
- Upstream feeder of the distance-calculation stage.
- On start, walks one filter window (fh rows x fw columns, row-major lowered indices) and emits every operand-index pair (idx1 < idx2) that becomes redundant under stride st in the lowered input feature map.
- A redundant pair is two positions in the same filter row whose column difference is a positive multiple of st.
- Pairs stream out over a valid/ready handshake, one per accepted cycle, and go directly to the distance calculator's idx1/idx2 inputs.

Parameters:
WORD_WIDTH, 8, width of indices, configuration fields and pair counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a walk; honoured only in IDLE
fw  input  WORD_WIDTH  filter width, sampled when start is accepted
fh  input  WORD_WIDTH  filter height, sampled when start is accepted
st  input  WORD_WIDTH  stride, sampled when start is accepted
out_ready  input  1  downstream ready
out_valid  output  1  idx1/idx2 hold a valid pair
idx1  output  WORD_WIDTH  smaller lowered index (r*fw + c1)
idx2  output  WORD_WIDTH  larger lowered index (r*fw + c2)
out_last  output  1  high with the final pair of the walk
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at end of walk
pair_cnt  output  WORD_WIDTH  number of pairs handshaked in current/last walk

Behaviour:
- Reset: state=IDLE; out_valid=0, idx1=0, idx2=0, out_last=0, busy=0, done=0, pair_cnt=0. Reset mid-walk aborts immediately; no done pulse is issued.
- Iteration order:
  - for r = 0..fh-1
  - for c1 = 0..fw-1
  - for c2 = c1+st, c1+2st, ... while c2 < fw
- Indices are built incrementally (row base += fw per row; c2 += st). No multiplier or divider.
- Configuration register widths:
  - Internal column comparisons use WORD_WIDTH+1 bits, so c2+st never wraps.
  - idx1/idx2 are truncated mod 2^WORD_WIDTH when fh*fw > 2^WORD_WIDTH. Such a configuration is out of spec; the walk still terminates.
- FSM states: IDLE, EMIT, DONE.
  - IDLE, start=1 at edge T:
    - latch fw/fh/st; pair_cnt:=0; busy:=1.
    - If no pair exists (fw==0, fh==0, st==0, or st>=fw): go to DONE.
    - Otherwise go to EMIT with the first pair (0, st) loaded and out_valid=1 from cycle T+1.
  - EMIT:
    - out_valid=1.
    - If out_valid && !out_ready: idx1, idx2 and out_last hold stable.
    - On out_valid && out_ready: pair_cnt += 1 and advance to the next pair in the same cycle, giving back-to-back throughput of 1 pair/cycle.
    - After the handshake of the pair with out_last=1: out_valid:=0, go to DONE.
  - out_last:
    - =1 exactly when the current pair is the final one: r==fh-1, and no later (c1,c2) remains in that row.
    - The final pair is always (fh-1)*fw + fw-1-st and (fh-1)*fw + fw-1.
  - DONE: done=1 for exactly one cycle; busy:=0; go to IDLE. pair_cnt holds its value until the next accepted start.
- Row skipping: when c1+st >= fw, c1 moves to the next row with c1=0. Rows never emit an empty cycle; every EMIT cycle carries a real pair.
- start while busy (EMIT/DONE) is ignored and does not disturb the walk. A start coinciding with reset is ignored.
- Input changes on fw/fh/st after acceptance have no effect until the next accepted start.
- Total pairs per walk = fh * sum over c1 of floor((fw-1-c1)/st).

Test Plan:
- fw=3, fh=1, st=1, out_ready=1 -> pairs (0,1),(0,2),(1,2) on consecutive cycles from start+1; out_last only on (1,2); done pulse next cycle; pair_cnt=3.
- fw=3, fh=2, st=2 -> pairs (0,2),(3,5); out_last on (3,5); pair_cnt=2; busy high from start+1 through the done cycle.
- fw=2, fh=3, st=2 (st>=fw), then st=0 -> out_valid never asserted; done pulses at start+1; pair_cnt=0.
- fw=4, fh=1, st=1 with out_ready toggling 1,0,0,1,... -> idx1/idx2 stable while stalled; sequence (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); pair_cnt=6, no drops or duplicates.
- Second start pulsed mid-walk of the fw=3/fh=1/st=1 case -> ignored; original sequence completes unchanged.
- reset asserted during the 2nd pair -> next cycle all outputs at reset values, no done; a fresh start then yields the full sequence from (0,1).

Source files
------------

// File: rtl/redundant_pair_generator.sv
// Walks one fh x fw filter window and streams every lowered-index pair that
// becomes redundant under stride st, one pair per accepted handshake.
module redundant_pair_generator #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] fw,
  input  logic [WORD_WIDTH-1:0] fh,
  input  logic [WORD_WIDTH-1:0] st,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] idx1,
  output logic [WORD_WIDTH-1:0] idx2,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] pair_cnt
);

  // Column arithmetic carries one extra bit so c + st never wraps.
  localparam int unsigned CW = WORD_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] fw_q, fh_q, st_q;
  logic [WORD_WIDTH-1:0] row_q, base_q;
  logic [CW-1:0]         c1_q, c2_q;

  logic [CW-1:0]         c2_step, c1_inc, c1_step;
  logic [WORD_WIDTH-1:0] nrow, nbase;
  logic [CW-1:0]         nc1, nc2;
  logic                  nlast;
  logic                  no_pair;
  logic                  first_last;

  // Successor of the current pair: next c2, else next c1, else next row.
  always_comb begin
    c2_step = c2_q + CW'(st_q);
    c1_inc  = c1_q + CW'(1);
    c1_step = c1_inc + CW'(st_q);
    nrow    = row_q;
    nbase   = base_q;
    nc1     = c1_q;
    nc2     = c2_step;
    if (c2_step < CW'(fw_q)) begin
      nc2 = c2_step;
    end else if (c1_step < CW'(fw_q)) begin
      nc1 = c1_inc;
      nc2 = c1_step;
    end else begin
      nrow  = row_q + WORD_WIDTH'(1);
      nbase = base_q + fw_q;
      nc1   = '0;
      nc2   = CW'(st_q);
    end
    nlast = ((CW'(nrow) + CW'(1)) == CW'(fh_q)) &&
            ((nc2 + CW'(st_q)) >= CW'(fw_q)) &&
            ((nc1 + CW'(1) + CW'(st_q)) >= CW'(fw_q));
  end

  // Decisions on the raw configuration at start acceptance.
  always_comb begin
    no_pair    = (fw == '0) || (fh == '0) || (st == '0) || (st >= fw);
    first_last = (fh == WORD_WIDTH'(1)) &&
                 ((CW'(st) + CW'(st)) >= CW'(fw)) &&
                 ((CW'(st) + CW'(1)) >= CW'(fw));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fw_q      <= '0;
      fh_q      <= '0;
      st_q      <= '0;
      row_q     <= '0;
      base_q    <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      out_valid <= 1'b0;
      idx1      <= '0;
      idx2      <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            fw_q     <= fw;
            fh_q     <= fh;
            st_q     <= st;
            pair_cnt <= '0;
            busy     <= 1'b1;
            if (no_pair) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= EMIT;
              row_q     <= '0;
              base_q    <= '0;
              c1_q      <= '0;
              c2_q      <= CW'(st);
              idx1      <= '0;
              idx2      <= st;
              out_last  <= first_last;
              out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            pair_cnt <= pair_cnt + WORD_WIDTH'(1);
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= DONE;
              done      <= 1'b1;
            end else begin
              row_q    <= nrow;
              base_q   <= nbase;
              c1_q     <= nc1;
              c2_q     <= nc2;
              idx1     <= nbase + WORD_WIDTH'(nc1);
              idx2     <= nbase + WORD_WIDTH'(nc2);
              out_last <= nlast;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
